mw_lmc1992_rx: RTL and testbench
================================

// Module: mw_lmc1992_rx
// PURPOSE
// - Microwire responder modelling the STE LMC1992 volume/tone controller; the far end of the shifter's
//   microwire master (data reg $FF8922, mask reg $FF8924).
// - Deserialises 11-bit frames, checks the device address, decodes the 3-bit function and holds the
//   mix/bass/treble/master/left/right settings; derives per-channel attenuation for the audio mixer.
// PARAMETERS
// - SYNC_STAGES  2  input synchroniser depth on mw_clk/mw_en_n/mw_data (0 = inputs already clk32-synchronous)
// - DEV_ADDR     2'b10  device address expected in frame bits [10:9]
// PORTS
// - clk32      in   1  system clock; sole clock
// - reset      in   1  synchronous, active-high reset
// - mw_clk     in   1  microwire clock; data sampled on its rising edge
// - mw_data    in   1  microwire serial data, MSB first
// - mw_en_n    in   1  microwire enable, active-low; frame framed by falling..rising edge
// - cmd_valid  out  1  one-cycle pulse: accepted command applied this cycle
// - cmd_err    out  1  one-cycle pulse: frame discarded (short, wrong address, fn 110/111)
// - mix        out  2  mixer setting (00 -12dB, 01 mix GI sound, 10 no mix, 11 reserved)
// - bass       out  4  bass, 0..12 (6 = flat, 2dB steps)
// - treble     out  4  treble, 0..12 (6 = flat)
// - master_vol out  6  master volume, 0..40 (40 = 0dB, 2dB steps)
// - left_vol   out  5  left volume, 0..20 (20 = 0dB)
// - right_vol  out  5  right volume, 0..20
// - att_left   out  6  (40-master_vol)+(20-left_vol), 2dB units, 0..60
// - att_right  out  6  (40-master_vol)+(20-right_vol)
// BEHAVIOUR
// - Reset: mix=01, bass=6, treble=6, master_vol=40, left_vol=right_vol=20, att_*=0, cmd_valid=cmd_err=0;
//   shift register and bit counter cleared; SYNC_STAGES flops preset to idle (mw_clk=0, mw_en_n=1, mw_data=0).
// - Edge detect on synchronised signals via one-cycle delayed copy; all edges clk32-sampled.
// - States: IDLE (en_n high) -> SHIFT on en_n falling edge (bit counter := 0, sreg untouched).
//   SHIFT: each mw_clk rising edge: sreg[10:0] := {sreg[9:0], mw_data}; bitcnt saturates at 15.
//   SHIFT -> EVAL on en_n rising edge; EVAL -> IDLE next cycle (single-cycle state).
// - EVAL: bitcnt<11 -> cmd_err. >11 bits -> last 11 received are used. sreg[10:9]!=DEV_ADDR -> cmd_err.
//   fn=sreg[8:6], d=sreg[5:0]: 000 mix:=d[1:0]; 001 bass:=min(d[3:0],12); 010 treble:=min(d[3:0],12);
//   011 master_vol:=min(d,40); 100 right_vol:=min(d[4:0],20); 101 left_vol:=min(d[4:0],20); 11x -> cmd_err.
// - Setting register and cmd_valid update in EVAL cycle; att_* registered, valid one cycle after cmd_valid.
// - Latency en_n rising (pin) -> cmd_valid = SYNC_STAGES+2 clk32 cycles.
// - mw_clk rising edge in same cycle as en_n rising: edge ignored, frame evaluated without it.
// - mw_clk edges while IDLE ignored; en_n falling while SHIFT cannot occur (level); glitch-free inputs required.
// - Reset mid-frame: partial frame dropped, no pulse; next frame needs a fresh en_n falling edge.
// - cmd_valid and cmd_err never asserted together; att_* arithmetic in 7 bits, result fits 6 bits.
// STRUCTURE
// - Shared package: LMC function codes (FN_MIX..FN_LVOL), DEV_ADDR default, reset defaults, clamp limits
//   (12, 40, 20), frame length 11.
// - Sub-module mw_deserializer: synchroniser, edge detect, bit counter, 11-bit sreg, frame_done/short
//   flags. Top holds decode, clamping, setting registers and attenuation.
// TESTING
// - After reset, no activity -> mix=01 bass=6 treble=6 master=40 left=right=20 att_left=att_right=0.
// - Frame 11'b10_011_101000 (master 40) then 11'b10_101_001010 (left 10) -> two cmd_valid; att_left=10, att_right=0.
// - Frame 11'b10_001_001111 (bass 15) -> bass=12 (clamped); 11'b10_011_111111 -> master_vol=40.
// - 9-bit frame -> cmd_err, no setting change; frame with address 01 -> cmd_err; fn 110 -> cmd_err.
// - 16 clocks with STE mask 0x07FF style: 5 leading junk bits then 10_100_000101 -> right_vol=5 (last 11 used).
// - Reset asserted after 6 bits -> no pulse; subsequent full frame 10_010_000011 -> treble=3, single cmd_valid.

Source files
------------

// File: rtl/mw_lmc1992_rx_pkg.sv
// Shared definitions for the LMC1992 microwire responder: function codes, FSM states,
// reset defaults, clamp limits and the clamp/attenuation helpers.
package mw_lmc1992_rx_pkg;

  typedef enum logic [2:0] {
    FN_MIX    = 3'b000,
    FN_BASS   = 3'b001,
    FN_TREBLE = 3'b010,
    FN_MASTER = 3'b011,
    FN_RVOL   = 3'b100,
    FN_LVOL   = 3'b101,
    FN_RSV6   = 3'b110,
    FN_RSV7   = 3'b111
  } lmc_fn_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_EVAL  = 2'b10
  } rx_state_e;

  localparam logic [1:0] DEV_ADDR_DEFAULT = 2'b10;
  localparam int         FRAME_LEN        = 11;
  localparam logic [3:0] FRAME_LEN_W      = 4'd11;
  localparam logic [3:0] BITCNT_MAX       = 4'd15;

  localparam logic [1:0] MIX_RST    = 2'b01;
  localparam logic [3:0] TONE_RST   = 4'd6;
  localparam logic [3:0] TONE_MAX   = 4'd12;
  localparam logic [5:0] MASTER_MAX = 6'd40;
  localparam logic [4:0] VOL_MAX    = 5'd20;

  typedef struct packed {
    logic [1:0] mix;
    logic [3:0] bass;
    logic [3:0] treble;
    logic [5:0] master;
    logic [4:0] left;
    logic [4:0] right;
  } lmc_settings_t;

  localparam lmc_settings_t SETTINGS_RST = '{
    mix:    MIX_RST,
    bass:   TONE_RST,
    treble: TONE_RST,
    master: MASTER_MAX,
    left:   VOL_MAX,
    right:  VOL_MAX
  };

  function automatic logic [3:0] clamp_tone(input logic [3:0] v);
    return (v > TONE_MAX) ? TONE_MAX : v;
  endfunction

  function automatic logic [5:0] clamp_master(input logic [5:0] v);
    return (v > MASTER_MAX) ? MASTER_MAX : v;
  endfunction

  function automatic logic [4:0] clamp_vol(input logic [4:0] v);
    return (v > VOL_MAX) ? VOL_MAX : v;
  endfunction

  // Inputs are already clamped, so each difference is non-negative and the sum is at most 60.
  function automatic logic [5:0] atten(input logic [5:0] master, input logic [4:0] vol);
    logic [6:0] sum;
    sum = (7'd40 - {1'b0, master}) + (7'd20 - {2'b00, vol});
    return sum[5:0];
  endfunction

endpackage

// File: rtl/mw_lmc1992_rx_deserializer.sv
// Microwire front end: input synchroniser, edge detection, frame FSM, bit counter and the
// 11-bit shift register holding the most recent bits of the frame.
module mw_lmc1992_rx_deserializer
  import mw_lmc1992_rx_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk32,
  input  logic        reset,
  input  logic        mw_clk_i,
  input  logic        mw_data_i,
  input  logic        mw_en_n_i,
  output logic        frame_done_o,
  output logic        frame_short_o,
  output logic [10:0] frame_o
);

  localparam logic [3:0] FLUSH_N = 4'(SYNC_STAGES);

  logic clk_s, en_s, dat_s;
  logic clk_d_q, en_d_q;
  logic clk_rise_s, en_rise_s, en_fall_s;
  logic [3:0] flush_q;
  logic armed_q;

  rx_state_e   state_q, state_d;
  logic [3:0]  bitcnt_q, bitcnt_d;
  logic [10:0] sreg_q, sreg_d;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign clk_s = mw_clk_i;
      assign en_s  = mw_en_n_i;
      assign dat_s = mw_data_i;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] clk_sync_q, en_sync_q, dat_sync_q;

      always_ff @(posedge clk32) begin
        if (reset) begin
          clk_sync_q <= '0;
          en_sync_q  <= '1;
          dat_sync_q <= '0;
        end else begin
          for (int i = SYNC_STAGES - 1; i > 0; i--) begin
            clk_sync_q[i] <= clk_sync_q[i-1];
            en_sync_q[i]  <= en_sync_q[i-1];
            dat_sync_q[i] <= dat_sync_q[i-1];
          end
          clk_sync_q[0] <= mw_clk_i;
          en_sync_q[0]  <= mw_en_n_i;
          dat_sync_q[0] <= mw_data_i;
        end
      end

      assign clk_s = clk_sync_q[SYNC_STAGES-1];
      assign en_s  = en_sync_q[SYNC_STAGES-1];
      assign dat_s = dat_sync_q[SYNC_STAGES-1];
    end
  endgenerate

  always_ff @(posedge clk32) begin
    if (reset) begin
      clk_d_q <= 1'b0;
      en_d_q  <= 1'b1;
    end else begin
      clk_d_q <= clk_s;
      en_d_q  <= en_s;
    end
  end

  assign clk_rise_s = clk_s & ~clk_d_q;
  assign en_rise_s  = en_s & ~en_d_q;
  assign en_fall_s  = ~en_s & en_d_q;

  // The synchroniser is preset to "idle"; if en_n is still low across a reset the flush would look
  // like a falling edge, so a frame is only accepted once en_n has been seen high after the flush.
  always_ff @(posedge clk32) begin
    if (reset) begin
      flush_q <= 4'd0;
      armed_q <= 1'b0;
    end else if (flush_q != FLUSH_N) begin
      flush_q <= flush_q + 4'd1;
      armed_q <= 1'b0;
    end else begin
      flush_q <= flush_q;
      armed_q <= armed_q | en_s;
    end
  end

  always_ff @(posedge clk32) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      bitcnt_q <= 4'd0;
      sreg_q   <= 11'd0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      sreg_q   <= sreg_d;
    end
  end

  // An mw_clk edge coinciding with en_n rising is dropped: the frame closes first.
  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    sreg_d   = sreg_q;
    case (state_q)
      ST_IDLE: begin
        if (en_fall_s && armed_q) begin
          state_d  = ST_SHIFT;
          bitcnt_d = 4'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (en_rise_s) begin
          state_d = ST_EVAL;
        end else if (clk_rise_s) begin
          sreg_d   = {sreg_q[9:0], dat_s};
          bitcnt_d = (bitcnt_q == BITCNT_MAX) ? BITCNT_MAX : bitcnt_q + 4'd1;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_EVAL: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign frame_done_o  = (state_q == ST_EVAL);
  assign frame_short_o = (bitcnt_q < FRAME_LEN_W);
  assign frame_o       = sreg_q;

endmodule

// File: rtl/mw_lmc1992_rx.sv
// LMC1992 volume/tone controller responder: decodes microwire frames into clamped settings
// and derives per-channel attenuation for the audio mixer.
module mw_lmc1992_rx
  import mw_lmc1992_rx_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [1:0] DEV_ADDR    = DEV_ADDR_DEFAULT
) (
  input  logic       clk32,
  input  logic       reset,
  input  logic       mw_clk,
  input  logic       mw_data,
  input  logic       mw_en_n,
  output logic       cmd_valid,
  output logic       cmd_err,
  output logic [1:0] mix,
  output logic [3:0] bass,
  output logic [3:0] treble,
  output logic [5:0] master_vol,
  output logic [4:0] left_vol,
  output logic [4:0] right_vol,
  output logic [5:0] att_left,
  output logic [5:0] att_right
);

  logic        frame_done_s;
  logic        frame_short_s;
  logic [10:0] frame_s;
  logic [5:0]  data_s;

  lmc_settings_t settings_q, settings_d;
  logic       cmd_valid_q, cmd_valid_d;
  logic       cmd_err_q, cmd_err_d;
  logic [5:0] att_left_q, att_right_q;

  mw_lmc1992_rx_deserializer #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_deser (
    .clk32        (clk32),
    .reset        (reset),
    .mw_clk_i     (mw_clk),
    .mw_data_i    (mw_data),
    .mw_en_n_i    (mw_en_n),
    .frame_done_o (frame_done_s),
    .frame_short_o(frame_short_s),
    .frame_o      (frame_s)
  );

  assign data_s = frame_s[5:0];

  always_comb begin
    settings_d  = settings_q;
    cmd_valid_d = 1'b0;
    cmd_err_d   = 1'b0;
    if (frame_done_s) begin
      if (frame_short_s || (frame_s[10:9] != DEV_ADDR)) begin
        cmd_err_d = 1'b1;
      end else begin
        cmd_valid_d = 1'b1;
        case (lmc_fn_e'(frame_s[8:6]))
          FN_MIX:    settings_d.mix    = data_s[1:0];
          FN_BASS:   settings_d.bass   = clamp_tone(data_s[3:0]);
          FN_TREBLE: settings_d.treble = clamp_tone(data_s[3:0]);
          FN_MASTER: settings_d.master = clamp_master(data_s);
          FN_RVOL:   settings_d.right  = clamp_vol(data_s[4:0]);
          FN_LVOL:   settings_d.left   = clamp_vol(data_s[4:0]);
          default: begin
            cmd_valid_d = 1'b0;
            cmd_err_d   = 1'b1;
          end
        endcase
      end
    end else begin
      cmd_valid_d = 1'b0;
      cmd_err_d   = 1'b0;
    end
  end

  // Attenuation follows the setting registers, so it lags cmd_valid by one cycle.
  always_ff @(posedge clk32) begin
    if (reset) begin
      settings_q  <= SETTINGS_RST;
      cmd_valid_q <= 1'b0;
      cmd_err_q   <= 1'b0;
      att_left_q  <= 6'd0;
      att_right_q <= 6'd0;
    end else begin
      settings_q  <= settings_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_err_q   <= cmd_err_d;
      att_left_q  <= atten(settings_q.master, settings_q.left);
      att_right_q <= atten(settings_q.master, settings_q.right);
    end
  end

  assign cmd_valid  = cmd_valid_q;
  assign cmd_err    = cmd_err_q;
  assign mix        = settings_q.mix;
  assign bass       = settings_q.bass;
  assign treble     = settings_q.treble;
  assign master_vol = settings_q.master;
  assign left_vol   = settings_q.left;
  assign right_vol  = settings_q.right;
  assign att_left   = att_left_q;
  assign att_right  = att_right_q;

endmodule

// File: tb/tb_mw_lmc1992_rx.sv
// Directed scoreboard bench for mw_lmc1992_rx: microwire frames are driven, expected
// outcomes queued, and each cmd_valid/cmd_err pulse is checked against the queue head.
module tb_mw_lmc1992_rx;

  logic       clk32   = 1'b0;
  logic       reset   = 1'b1;
  logic       mw_clk  = 1'b0;
  logic       mw_data = 1'b0;
  logic       mw_en_n = 1'b1;
  logic       cmd_valid, cmd_err;
  logic [1:0] mix;
  logic [3:0] bass, treble;
  logic [5:0] master_vol, att_left, att_right;
  logic [4:0] left_vol, right_vol;

  mw_lmc1992_rx dut (
    .clk32     (clk32),
    .reset     (reset),
    .mw_clk    (mw_clk),
    .mw_data   (mw_data),
    .mw_en_n   (mw_en_n),
    .cmd_valid (cmd_valid),
    .cmd_err   (cmd_err),
    .mix       (mix),
    .bass      (bass),
    .treble    (treble),
    .master_vol(master_vol),
    .left_vol  (left_vol),
    .right_vol (right_vol),
    .att_left  (att_left),
    .att_right (att_right)
  );

  always #5 clk32 = ~clk32;

  typedef struct {
    logic       err;
    logic [1:0] mix;
    logic [3:0] bass;
    logic [3:0] treble;
    logic [5:0] master;
    logic [4:0] left;
    logic [4:0] right;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   passed = 0;
  int   total  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
  endtask

  task automatic set_defaults();
    cur.err    = 1'b0;
    cur.mix    = 2'b01;
    cur.bass   = 4'd6;
    cur.treble = 4'd6;
    cur.master = 6'd40;
    cur.left   = 5'd20;
    cur.right  = 5'd20;
  endtask

  task automatic push_exp(input logic err);
    exp_t e;
    e     = cur;
    e.err = err;
    sb.push_back(e);
  endtask

  task automatic check_settings(input string tag, input exp_t e);
    chk({tag, "_mix"},    32'(mix),        32'(e.mix));
    chk({tag, "_bass"},   32'(bass),       32'(e.bass));
    chk({tag, "_treble"}, 32'(treble),     32'(e.treble));
    chk({tag, "_master"}, 32'(master_vol), 32'(e.master));
    chk({tag, "_left"},   32'(left_vol),   32'(e.left));
    chk({tag, "_right"},  32'(right_vol),  32'(e.right));
  endtask

  task automatic check_att(input string tag, input exp_t e);
    int al, ar;
    al = (40 - int'(e.master)) + (20 - int'(e.left));
    ar = (40 - int'(e.master)) + (20 - int'(e.right));
    chk({tag, "_att_left"},  32'(att_left),  al);
    chk({tag, "_att_right"}, 32'(att_right), ar);
  endtask

  task automatic send_bits(input logic [15:0] bits, input int n);
    @(negedge clk32);
    mw_en_n = 1'b0;
    repeat (3) @(negedge clk32);
    for (int i = n - 1; i >= 0; i--) begin
      mw_data = bits[i];
      repeat (2) @(negedge clk32);
      mw_clk = 1'b1;
      repeat (3) @(negedge clk32);
      mw_clk = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [15:0] bits, input int n);
    send_bits(bits, n);
    repeat (2) @(negedge clk32);
    mw_en_n = 1'b1;
  endtask

  task automatic wait_pulse(input string tag);
    exp_t e;
    bit   seen;
    logic v, er;
    int   extra;
    seen = 1'b0;
    v    = 1'b0;
    er   = 1'b0;
    if (sb.size() == 0) begin
      chk({tag, "_sb_nonempty"}, 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk32);
      if (cmd_valid || cmd_err) begin
        seen = 1'b1;
        v    = cmd_valid;
        er   = cmd_err;
      end
    end
    chk({tag, "_seen"},  32'(seen), 32'd1);
    chk({tag, "_valid"}, 32'(v),    32'(!e.err));
    chk({tag, "_err"},   32'(er),   32'(e.err));
    check_settings(tag, e);
    @(negedge clk32);
    check_att(tag, e);
    extra = 0;
    repeat (10) begin
      @(negedge clk32);
      if (cmd_valid || cmd_err) extra++;
    end
    chk({tag, "_single"}, 32'(extra), 32'd0);
  endtask

  initial begin
    int pulses;
    set_defaults();
    reset = 1'b1;
    repeat (4) @(negedge clk32);
    reset = 1'b0;
    repeat (8) @(negedge clk32);
    chk("rst_valid", 32'(cmd_valid), 32'd0);
    chk("rst_err",   32'(cmd_err),   32'd0);
    check_settings("rst", cur);
    check_att("rst", cur);

    cur.master = 6'd40; push_exp(1'b0);
    send_frame(16'b10_011_101000, 11); wait_pulse("master40");

    cur.left = 5'd10; push_exp(1'b0);
    send_frame(16'b10_101_001010, 11); wait_pulse("left10");

    cur.bass = 4'd12; push_exp(1'b0);
    send_frame(16'b10_001_001111, 11); wait_pulse("bass_clamp");

    cur.master = 6'd40; push_exp(1'b0);
    send_frame(16'b10_011_111111, 11); wait_pulse("master_clamp");

    push_exp(1'b1);
    send_frame(16'b10_011_0000, 9); wait_pulse("short9");

    push_exp(1'b1);
    send_frame(16'b01_011_000000, 11); wait_pulse("bad_addr");

    push_exp(1'b1);
    send_frame(16'b10_110_000001, 11); wait_pulse("fn110");

    cur.right = 5'd5; push_exp(1'b0);
    send_frame(16'b11111_10_100_000101, 16); wait_pulse("long16_right5");

    cur.mix = 2'b10; push_exp(1'b0);
    send_frame(16'b10_000_000010, 11); wait_pulse("mix_nomix");

    cur.master = 6'd30; push_exp(1'b0);
    send_frame(16'b10_011_011110, 11); wait_pulse("master30");

    send_bits(16'b10_010_0, 6);
    @(negedge clk32);
    reset   = 1'b1;
    mw_en_n = 1'b1;
    repeat (4) @(negedge clk32);
    reset = 1'b0;
    pulses = 0;
    repeat (20) begin
      @(negedge clk32);
      if (cmd_valid || cmd_err) pulses++;
    end
    chk("midrst_no_pulse", 32'(pulses), 32'd0);
    set_defaults();
    check_settings("midrst", cur);
    check_att("midrst", cur);

    cur.treble = 4'd3; push_exp(1'b0);
    send_frame(16'b10_010_000011, 11); wait_pulse("treble3");

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
